// File: rtl/mac_result_drain.sv
// Job sequencer and requantizing output drain for the 4-column MAC array.
// Clears the array, enables it for acc_len cycles, snapshots the columns, then streams them out.
module mac_result_drain #(
   parameter int unsigned ACC_WIDTH = 24,
   parameter int unsigned NUM_COL   = 4,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned SH_WIDTH  = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           acc_len,
   input  logic [SH_WIDTH-1:0]            shift,
   output logic                           busy,
   output logic                           mac_clr,
   output logic                           mac_en,
   input  logic [NUM_COL*ACC_WIDTH-1:0]   y_in,
   output logic [OUT_WIDTH-1:0]           out_data,
   output logic [$clog2(NUM_COL)-1:0]     out_col,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           sat_flag,
   output logic                           done
);

   localparam int unsigned ColW = $clog2(NUM_COL);
   localparam logic [ColW-1:0] LastCol = ColW'(NUM_COL - 1);
   localparam logic [SH_WIDTH-1:0] ShMax = SH_WIDTH'(ACC_WIDTH - 1);
   localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH:0] SatMin = (ACC_WIDTH + 1)'(-(2 ** (OUT_WIDTH - 1)));

   typedef enum logic [2:0] {StIdle, StClear, StAccum, StSettle, StDrain} state_e;

   state_e                 state_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [SH_WIDTH-1:0]    shift_q;
   logic [ACC_WIDTH-1:0]   snap_q [NUM_COL];
   logic                   beat_sat_q;

   logic [ColW-1:0]        nxt_col;
   logic [ACC_WIDTH-1:0]   req_src;
   logic [OUT_WIDTH:0]     req;

   // Returns {saturated, value}; the extra top bit keeps x + rounding from overflowing.
   function automatic logic [OUT_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                  input logic [SH_WIDTH-1:0]  sh);
      logic signed [ACC_WIDTH:0] rnd;
      logic signed [ACC_WIDTH:0] t;
      logic signed [ACC_WIDTH:0] r;
      logic [OUT_WIDTH-1:0]      q;
      logic                      sat;
      rnd = '0;
      if (sh != '0) rnd = (ACC_WIDTH + 1)'(1) << (sh - SH_WIDTH'(1));
      t = $signed({x[ACC_WIDTH-1], x}) + rnd;
      r = t >>> sh;
      if (r > SatMax) begin
         q   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
         sat = 1'b1;
      end else if (r < SatMin) begin
         q   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
         sat = 1'b1;
      end else begin
         q   = r[OUT_WIDTH-1:0];
         sat = 1'b0;
      end
      return {sat, q};
   endfunction

   // Column 0 is requantized straight from y_in so it is ready the cycle DRAIN starts.
   always_comb begin
      nxt_col = out_col + ColW'(1);
      req_src = (state_q == StSettle) ? y_in[ACC_WIDTH-1:0] : snap_q[nxt_col];
      req     = requant(req_src, shift_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         beat_sat_q <= 1'b0;
         busy       <= 1'b0;
         mac_clr    <= 1'b0;
         mac_en     <= 1'b0;
         out_data   <= '0;
         out_col    <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         sat_flag   <= 1'b0;
         done       <= 1'b0;
         for (int c = 0; c < NUM_COL; c++) snap_q[c] <= '0;
      end else begin
         mac_clr <= 1'b0;
         done    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  cnt_q    <= acc_len;
                  shift_q  <= (shift > ShMax) ? ShMax : shift;
                  sat_flag <= 1'b0;
                  mac_clr  <= 1'b1;
                  busy     <= 1'b1;
                  state_q  <= StClear;
               end
            end
            StClear: begin
               if (cnt_q != '0) begin
                  mac_en  <= 1'b1;
                  state_q <= StAccum;
               end else begin
                  state_q <= StSettle;
               end
            end
            StAccum: begin
               if (cnt_q == CNT_WIDTH'(1)) begin
                  mac_en  <= 1'b0;
                  state_q <= StSettle;
               end else begin
                  cnt_q <= cnt_q - CNT_WIDTH'(1);
               end
            end
            StSettle: begin
               for (int c = 0; c < NUM_COL; c++) snap_q[c] <= y_in[c*ACC_WIDTH +: ACC_WIDTH];
               out_valid  <= 1'b1;
               out_col    <= '0;
               out_data   <= req[OUT_WIDTH-1:0];
               beat_sat_q <= req[OUT_WIDTH];
               out_last   <= 1'b0;
               state_q    <= StDrain;
            end
            StDrain: begin
               if (out_ready) begin
                  sat_flag <= sat_flag | beat_sat_q;
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_q   <= StIdle;
                  end else begin
                     out_col    <= nxt_col;
                     out_data   <= req[OUT_WIDTH-1:0];
                     beat_sat_q <= req[OUT_WIDTH];
                     out_last   <= (nxt_col == LastCol);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: a behavioural MAC array feeds y_in, a scoreboard checks the drain.
module tb_mac_result_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  acc_len;
   logic [4:0]  shift;
   logic        busy;
   logic        mac_clr;
   logic        mac_en;
   logic [95:0] y_in;
   logic [7:0]  out_data;
   logic [1:0]  out_col;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        sat_flag;
   logic        done;

   int errors = 0;
   int checks = 0;

   mac_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .acc_len   (acc_len),
      .shift     (shift),
      .busy      (busy),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .y_in      (y_in),
      .out_data  (out_data),
      .out_col   (out_col),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .sat_flag  (sat_flag),
      .done      (done)
   );

   always #5 clk = ~clk;

   // MAC array stand-in: a = {3,-2,7,1}, b = {4,5,-1,1}, one-cycle register latency.
   int prod [4] = '{12, -10, -7, 1};
   logic signed [23:0] acc [4];
   always @(posedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (rst) acc[c] <= '0;
         else if (mac_clr) acc[c] <= '0;
         else if (mac_en) acc[c] <= acc[c] + 24'(prod[c]);
      end
   end
   assign y_in = {acc[3], acc[2], acc[1], acc[0]};

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int data;
      int col;
      int last;
   } beat_t;
   beat_t exp_q[$];

   bit toggle = 1'b0;
   int en_cnt = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = toggle ? ~out_ready : 1'b1;
      end
   end

   // Monitor: scoreboard pops on every transfer, plus stall stability and done timing.
   bit          done_due = 1'b0;
   bit          stall_prev = 1'b0;
   logic [7:0]  prev_data;
   logic [1:0]  prev_col;
   logic        prev_last;
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (mac_en) en_cnt++;
         chk("done_pulse", done, done_due);
         if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", $signed(out_data), $signed(prev_data));
            chk("stall_col", out_col, prev_col);
            chk("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", $signed(out_data), e.data);
               chk("beat_col", out_col, e.col);
               chk("beat_last", out_last, e.last);
            end
         end
         done_due   = out_valid && out_ready && out_last;
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_col   = out_col;
         prev_last  = out_last;
      end
   end

   task automatic run_job(input int len, input int sh, input bit restart,
                          input int e0, input int e1, input int e2, input int e3,
                          input int exp_sat);
      int  cycles;
      int  n;
      bit  seen;
      bit  got;
      exp_q.push_back('{e0, 0, 0});
      exp_q.push_back('{e1, 1, 0});
      exp_q.push_back('{e2, 2, 0});
      exp_q.push_back('{e3, 3, 1});
      en_cnt  = 0;
      acc_len = 8'(len);
      shift   = 5'(sh);
      start   = 1'b1;
      cycles  = 0;
      seen    = 1'b0;
      while (!seen && cycles < 300) begin
         @(posedge clk);
         cycles++;
         #1;
         start = restart && (cycles == 4);
         if (cycles == 1) chk("sat_clear_at_start", sat_flag, 0);
         if (out_valid) seen = 1'b1;
      end
      chk("first_valid_latency", cycles, len + 3);
      n   = 0;
      got = 1'b0;
      while (!got && n < 300) begin
         @(posedge clk);
         n++;
         #1;
         if (done) got = 1'b1;
      end
      chk("done_seen", got, 1);
      chk("sat_flag", sat_flag, exp_sat);
      chk("mac_en_cycles", en_cnt, len);
      chk("queue_drained", exp_q.size(), 0);
      @(posedge clk);
      #1;
      chk("idle_after_done", busy, 0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      acc_len = '0;
      shift   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_col", out_col, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_job(10, 0, 1'b0, 120, -100, -70, 10, 0);
      run_job(10, 2, 1'b0, 30, -25, -17, 3, 0);
      run_job(20, 0, 1'b0, 127, -128, -128, 20, 1);
      run_job(1, 0, 1'b0, 12, -10, -7, 1, 0);

      toggle = 1'b1;
      run_job(10, 0, 1'b0, 120, -100, -70, 10, 0);
      toggle = 1'b0;
      @(posedge clk);
      #1;

      run_job(10, 0, 1'b1, 120, -100, -70, 10, 0);

      // Abort a job mid-ACCUM
      acc_len = 8'd10;
      shift   = 5'd0;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("accum_mac_en", mac_en, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_mac_en", mac_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_stays_idle", busy, 0);
      chk("abort_no_valid", out_valid, 0);

      run_job(10, 0, 1'b0, 120, -100, -70, 10, 0);
      run_job(0, 3, 1'b0, 0, 0, 0, 0, 0);

      repeat (10) @(posedge clk);
      #1;
      chk("no_extra_beats", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
